pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
- Parametrised, fully pipelined signed adder tree for the NPU MAC array.
- Reduces N_INPUTS products per beat to one sum, with a register after every tree level.
- Accumulates successive beats (valid/last framing) into one output word per frame, e.g. a convolution window spread over several cycles.
- Sits between the MAC column outputs and the requantise/activation stage.

Parameters:
N_INPUTS, 9, number of signed operands per beat (>=2; need not be a power of two)
IN_WIDTH, 32, width of each signed operand (MAC product width)
ACC_GUARD, 4, extra accumulator guard bits for multi-beat frames
LEVELS, $clog2(N_INPUTS), derived; number of tree levels, not overridable
OUT_WIDTH, IN_WIDTH+LEVELS+ACC_GUARD, derived; output and accumulator width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_last  input  1  final beat of frame; sampled only when in_valid=1
in_data  input  N_INPUTS*IN_WIDTH  packed signed operands; operand k at [k*IN_WIDTH +: IN_WIDTH]
out_valid  output  1  one-cycle pulse; out_data holds a completed frame sum
out_data  output  OUT_WIDTH  signed frame sum
out_beats  output  16  number of beats in the emitted frame (saturates at 16'hFFFF)
busy  output  1  high while any beat is in the tree or a partial frame is held

Behaviour:
- Reset: clk and reset as above. Reset is asynchronous and active-low; all pipeline data, valid and last registers, accumulator, beat counter, out_valid, out_data and out_beats are cleared to 0 immediately on reset=0.
- Reset mid-frame discards the partial sum and all in-flight beats. The first valid beat after reset starts a new frame.
- Tree level L (1..LEVELS):
  - Pairs operands 2i and 2i+1, sign-extended by 1 bit.
  - An odd leftover operand is sign-extended and passed through a register. It is never combinationally added at the end.
  - Every level output is registered. in_valid and in_last travel in a matching shift register.
- Tree latency: LEVELS cycles from the in_valid edge to tree_valid. For N_INPUTS=9 this is 4.
- Accumulator stage: 1 cycle.
  - tree_valid with an empty accumulator: acc <= sext(tree_sum), beats <= 1.
  - tree_valid otherwise: acc <= acc + sext(tree_sum), beats <= beats+1.
  - tree_valid and tree_last: out_data <= that same new sum, out_valid <= 1, out_beats <= new count. The accumulator is marked empty in the same cycle.
  - Total latency from the last beat to out_valid: LEVELS+1 cycles.
- Single-beat frame (in_valid and in_last together): out_data = sum of that beat after LEVELS+1 cycles.
- Throughput: one beat per cycle with no bubbles. A new frame may start on the cycle immediately after a last beat.
- No backpressure: the consumer must accept every out_valid pulse. out_data holds its value until the next emission.
- in_valid=0 cycles within a frame are permitted. They do not advance the accumulator.
- Overflow (default build): two's-complement wrap at OUT_WIDTH.
- busy = OR of the valid shift register, OR the accumulator being non-empty.

Optional Feature:
Macro ADDER_TREE_SAT_EN.
- Defined: the accumulator add saturates to the most positive or most negative OUT_WIDTH value. A sticky per-frame sat_flag output (1 bit) is added; it is asserted with out_valid when any clamp occurred in that frame, and cleared at frame start and on reset.
- Undefined: plain wrap-around arithmetic, and the sat_flag port is absent.

Decomposition:
- Package npu_pkg:
  - clog2-based width helper function;
  - default DATA_WIDTH/MAC_WIDTH constants;
  - the OUT_WIDTH derivation, so the MAC array and requantiser share it.
- Sub-module adder_tree_level:
  - one registered reduction level parametrised by input count and width, including odd passthrough and valid/last pipelining;
  - the top instantiates it LEVELS times in a generate loop, then the accumulator.

Test Plan:
- N=9, single beat with operands 1..9, in_last=1 -> out_valid exactly 5 cycles later, out_data=45, out_beats=1.
- N=9, 3 back-to-back beats each all-operands=-2, last on beat 3 -> one out_valid pulse, out_data=-54, out_beats=3, busy low the cycle after.
- Back-to-back single-beat frames with all operands equal to 5, then all equal to 7, on consecutive cycles -> out_valid on 2 consecutive cycles, out_data 45 then 63 (no inter-frame leakage).
- Frame with idle gaps (beat, 2 idle cycles, last beat; operands all 1) -> out_data=18, out_beats=2.
- Reset asserted while a 2-beat frame is mid-tree -> no out_valid; the next single-beat frame of all 3s yields 27.
- N=9, IN_WIDTH=32, 16 beats of all operands 0x7FFFFFFF:
  - without ADDER_TREE_SAT_EN -> out_data equals the wrapped 2's-complement sum;
  - with ADDER_TREE_SAT_EN and ACC_GUARD=0 -> out_data = max positive, sat_flag=1.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU width constants and helpers used by the MAC array, adder tree and requantiser.
package npu_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned MAC_WIDTH     = 32;
    localparam int unsigned ACC_GUARD_DEF = 4;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a tree sum plus accumulator guard bits.
    function automatic int unsigned tree_out_width(input int unsigned n_inputs,
                                                   input int unsigned in_width,
                                                   input int unsigned acc_guard);
        return in_width + clog2_f(n_inputs) + acc_guard;
    endfunction

    // Operand count remaining after l pairwise reduction levels.
    function automatic int unsigned level_count(input int unsigned n_inputs,
                                                input int unsigned l);
        int unsigned c;
        c = n_inputs;
        for (int unsigned i = 0; i < l; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise reduction level; an odd leftover operand is sign-extended and registered.
module adder_tree_level #(
    parameter  int unsigned N_IN  = 2,
    parameter  int unsigned W_IN  = 8,
    localparam int unsigned N_OUT = (N_IN + 1) / 2,
    localparam int unsigned W_OUT = W_IN + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [N_IN*W_IN-1:0]   in_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [N_OUT*W_OUT-1:0] out_data
);

    localparam int unsigned N_PAIRS = N_IN / 2;
    localparam bit          HAS_ODD = (N_IN % 2) == 1;

    logic [N_OUT*W_OUT-1:0] w_next;

    always_comb begin
        w_next = '0;
        for (int unsigned i = 0; i < N_PAIRS; i++) begin
            w_next[i*W_OUT +: W_OUT] =
                W_OUT'($signed(in_data[(2*i)*W_IN +: W_IN])) +
                W_OUT'($signed(in_data[(2*i+1)*W_IN +: W_IN]));
        end
        if (HAS_ODD) begin
            w_next[(N_OUT-1)*W_OUT +: W_OUT] =
                W_OUT'($signed(in_data[(N_IN-1)*W_IN +: W_IN]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid & in_last;
            if (in_valid) begin
                out_data <= w_next;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with valid/last frame accumulation.
// Define ADDER_TREE_SAT_EN for a saturating accumulator and the sat_flag output.
module pipelined_adder_tree
    import npu_pkg::*;
#(
    parameter  int unsigned N_INPUTS  = 9,
    parameter  int unsigned IN_WIDTH  = MAC_WIDTH,
    parameter  int unsigned ACC_GUARD = ACC_GUARD_DEF,
    localparam int unsigned LEVELS    = clog2_f(N_INPUTS),
    localparam int unsigned OUT_WIDTH = tree_out_width(N_INPUTS, IN_WIDTH, ACC_GUARD)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [15:0]                  out_beats,
`ifdef ADDER_TREE_SAT_EN
    output logic                         sat_flag,
`endif
    output logic                         busy
);

    localparam int unsigned TREE_WIDTH = IN_WIDTH + LEVELS;

    logic [LEVELS-1:0]     w_lvl_vin;
    logic [TREE_WIDTH-1:0] w_tree_sum;
    logic                  w_tree_valid;
    logic                  w_tree_last;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned NI = level_count(N_INPUTS, l);
        localparam int unsigned WI = IN_WIDTH + l;
        localparam int unsigned NO = (NI + 1) / 2;
        localparam int unsigned WO = WI + 1;

        logic [NI*WI-1:0] w_din;
        logic             w_vin;
        logic             w_lin;
        logic [NO*WO-1:0] w_dout;
        logic             w_vout;
        logic             w_lout;

        if (l == 0) begin : g_first
            assign w_din = in_data;
            assign w_vin = in_valid;
            assign w_lin = in_last;
        end else begin : g_next
            assign w_din = g_lvl[l-1].w_dout;
            assign w_vin = g_lvl[l-1].w_vout;
            assign w_lin = g_lvl[l-1].w_lout;
        end

        assign w_lvl_vin[l] = w_vin;

        adder_tree_level #(
            .N_IN (NI),
            .W_IN (WI)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (w_vin),
            .in_last   (w_lin),
            .in_data   (w_din),
            .out_valid (w_vout),
            .out_last  (w_lout),
            .out_data  (w_dout)
        );
    end

    assign w_tree_sum   = g_lvl[LEVELS-1].w_dout;
    assign w_tree_valid = g_lvl[LEVELS-1].w_vout;
    assign w_tree_last  = g_lvl[LEVELS-1].w_lout;

    logic [OUT_WIDTH-1:0] r_acc;
    logic [15:0]          r_beats;
    logic                 r_acc_valid;
    logic                 r_busy;

    logic [OUT_WIDTH-1:0] w_tree_ext;
    logic [OUT_WIDTH-1:0] w_base;
    logic [OUT_WIDTH-1:0] w_acc_next;
    logic [15:0]          w_beats_next;
    logic                 w_acc_valid_next;
    logic                 w_busy_next;

`ifdef ADDER_TREE_SAT_EN
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MAX_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                 r_sat;
    logic [OUT_WIDTH:0]   w_wide;
    logic                 w_clamp;
    logic                 w_sat_next;
`endif

    // Accumulator next-state: an empty accumulator contributes zero so a new frame starts from the tree sum.
    always_comb begin
        w_tree_ext       = OUT_WIDTH'($signed(w_tree_sum));
        w_base           = r_acc_valid ? r_acc : '0;
        w_acc_next       = '0;
        w_beats_next     = 16'd1;
        w_acc_valid_next = r_acc_valid;
`ifdef ADDER_TREE_SAT_EN
        w_wide     = {w_base[OUT_WIDTH-1], w_base} + {w_tree_ext[OUT_WIDTH-1], w_tree_ext};
        w_clamp    = w_wide[OUT_WIDTH] != w_wide[OUT_WIDTH-1];
        w_sat_next = (r_acc_valid & r_sat) | w_clamp;
        if (w_clamp) begin
            w_acc_next = w_wide[OUT_WIDTH] ? MAX_NEG : MAX_POS;
        end else begin
            w_acc_next = w_wide[OUT_WIDTH-1:0];
        end
`else
        w_acc_next = w_base + w_tree_ext;
`endif
        if (r_acc_valid) begin
            w_beats_next = (r_beats == 16'hFFFF) ? 16'hFFFF : r_beats + 16'd1;
        end
        if (w_tree_valid) begin
            w_acc_valid_next = ~w_tree_last;
        end
        // Registered busy tracks the next state of every valid bit, so it has no extra lag.
        w_busy_next = (|w_lvl_vin) | w_acc_valid_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_beats     <= '0;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_beats   <= '0;
`ifdef ADDER_TREE_SAT_EN
            r_sat       <= 1'b0;
            sat_flag    <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            r_busy    <= w_busy_next;
            if (w_tree_valid) begin
                if (w_tree_last) begin
                    out_valid   <= 1'b1;
                    out_data    <= w_acc_next;
                    out_beats   <= w_beats_next;
                    r_acc       <= '0;
                    r_beats     <= '0;
                    r_acc_valid <= 1'b0;
`ifdef ADDER_TREE_SAT_EN
                    sat_flag    <= w_sat_next;
                    r_sat       <= 1'b0;
`endif
                end else begin
                    r_acc       <= w_acc_next;
                    r_beats     <= w_beats_next;
                    r_acc_valid <= 1'b1;
`ifdef ADDER_TREE_SAT_EN
                    r_sat       <= w_sat_next;
`endif
                end
            end
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed self-checking bench for pipelined_adder_tree (N_INPUTS=9, IN_WIDTH=32).
module tb_pipelined_adder_tree;

    localparam int unsigned N  = 9;
    localparam int unsigned W  = 32;
`ifdef ADDER_TREE_SAT_EN
    localparam int unsigned G  = 0;
`else
    localparam int unsigned G  = 4;
`endif
    localparam int unsigned OW = W + 4 + G;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_last;
    logic [N*W-1:0]    in_data;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic [15:0]       out_beats;
    logic              busy;
`ifdef ADDER_TREE_SAT_EN
    logic              sat_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipelined_adder_tree #(
        .N_INPUTS  (N),
        .IN_WIDTH  (W),
        .ACC_GUARD (G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_beats (out_beats),
`ifdef ADDER_TREE_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ev(input longint v);
        logic [OW-1:0] t;
        t = OW'(v);
        return 64'(t);
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = v;
        return r;
    endfunction

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(k + 1);
        return r;
    endfunction

    task automatic drive(input logic v, input logic l, input logic [N*W-1:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0);
    endtask

    // Step until out_valid is seen, bounded to 20 cycles.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        int seen;
        logic [OW-1:0] max_pos;
        max_pos = {1'b0, {(OW-1){1'b1}}};

        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_beats", 64'(out_beats), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        reset = 1'b1;
        step();

        // Single beat 1..9 with last: out_valid exactly LEVELS+1 edges after sampling.
        drive(1'b1, 1'b1, ramp());
        step();
        idle();
        chk("t1_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_early_valid", 64'(out_valid), 64'd0);
            step();
        end
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data",  64'(out_data),  ev(45));
        chk("t1_beats", 64'(out_beats), 64'd1);
        chk("t1_busy_done", 64'(busy),  64'd0);
`ifdef ADDER_TREE_SAT_EN
        chk("t1_sat", 64'(sat_flag), 64'd0);
`endif
        step();
        chk("t1_pulse", 64'(out_valid), 64'd0);
        chk("t1_hold",  64'(out_data),  ev(45));

        // Three back-to-back beats of -2.
        drive(1'b1, 1'b0, fill(W'(-2)));
        step();
        drive(1'b1, 1'b0, fill(W'(-2)));
        step();
        drive(1'b1, 1'b1, fill(W'(-2)));
        step();
        idle();
        wait_out("t2_valid");
        chk("t2_data",  64'(out_data),  ev(-54));
        chk("t2_beats", 64'(out_beats), 64'd3);
        step();
        chk("t2_pulse", 64'(out_valid), 64'd0);
        chk("t2_busy_after", 64'(busy), 64'd0);

        // Back-to-back single-beat frames.
        drive(1'b1, 1'b1, fill(W'(5)));
        step();
        drive(1'b1, 1'b1, fill(W'(7)));
        step();
        idle();
        wait_out("t3_valid_a");
        chk("t3_data_a",  64'(out_data),  ev(45));
        chk("t3_beats_a", 64'(out_beats), 64'd1);
        step();
        chk("t3_valid_b", 64'(out_valid), 64'd1);
        chk("t3_data_b",  64'(out_data),  ev(63));
        chk("t3_beats_b", 64'(out_beats), 64'd1);
        step();
        chk("t3_pulse", 64'(out_valid), 64'd0);

        // Frame with two idle cycles between beats.
        drive(1'b1, 1'b0, fill(W'(1)));
        step();
        idle();
        step();
        step();
        drive(1'b1, 1'b1, fill(W'(1)));
        step();
        idle();
        wait_out("t4_valid");
        chk("t4_data",  64'(out_data),  ev(18));
        chk("t4_beats", 64'(out_beats), 64'd2);

        // Reset while a two-beat frame is inside the tree.
        step();
        drive(1'b1, 1'b0, fill(W'(1)));
        step();
        drive(1'b1, 1'b1, fill(W'(1)));
        step();
        idle();
        step();
        reset = 1'b0;
        #1;
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_busy",  64'(busy),      64'd0);
        chk("t5_async_data",  64'(out_data),  64'd0);
        step();
        step();
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        chk("t5_no_valid", 64'(seen), 64'd0);
        drive(1'b1, 1'b1, fill(W'(3)));
        step();
        idle();
        wait_out("t5_valid");
        chk("t5_data",  64'(out_data),  ev(27));
        chk("t5_beats", 64'(out_beats), 64'd1);

        // Sixteen beats of max positive operands.
        step();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, (k == 15), fill(32'h7FFF_FFFF));
            step();
        end
        idle();
        wait_out("t6_valid");
        chk("t6_beats", 64'(out_beats), 64'd16);
`ifdef ADDER_TREE_SAT_EN
        chk("t6_data_sat", 64'(out_data), 64'(max_pos));
        chk("t6_sat_flag", 64'(sat_flag), 64'd1);
`else
        chk("t6_data_wrap", 64'(out_data), 64'h47_FFFF_FF70);
`endif
        step();
        chk("t6_busy_after", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
